// File: rtl/fec_fifo_wr_arbiter.sv
// fec_fifo_wr_arbiter: round-robin FIFO write-port arbiter that grants whole FEC frames.
// Optional idle watchdog inside a frame: define ARB_WATCHDOG_EN.
module fec_fifo_wr_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int WIDTH       = 8,
    parameter int FRAME_LEN   = 8,
    parameter int WDOG_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     abort
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(FRAME_LEN);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state;
    logic [PW-1:0]       rr_ptr, owner, owner_nxt, pick;
    logic [CW-1:0]       word_cnt;
    logic [NUM_REQ-1:0]  rot;
    logic [PW:0]         s;
    logic                xfer;

`ifdef ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog;
`else
    assign abort = 1'b0;
`endif

    // rot[k] is the valid bit of requester (rr_ptr + k) mod NUM_REQ; lowest k wins
    always_comb begin
        rot  = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
        pick = rr_ptr;
        s    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, rr_ptr} + (PW+1)'(k);
            if (s >= (PW+1)'(NUM_REQ)) s = s - (PW+1)'(NUM_REQ);
            if (rot[k]) pick = s[PW-1:0];
        end
    end

    assign owner_nxt  = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
    assign xfer       = (state == BURST) && req_valid[owner] && !fifo_full;
    assign req_ready  = fifo_full ? '0 : grant;
    assign fifo_wr_en = xfer;
    assign fifo_data  = xfer ? req_data[owner*WIDTH +: WIDTH] : '0;
    assign busy       = (state == BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            owner      <= '0;
            word_cnt   <= '0;
            frame_done <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            wdog       <= '0;
            abort      <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            abort      <= 1'b0;
`endif
            if (state == IDLE) begin
                if (|req_valid) begin
                    state    <= BURST;
                    owner    <= pick;
                    grant    <= NUM_REQ'(1) << pick;
                    word_cnt <= '0;
`ifdef ARB_WATCHDOG_EN
                    wdog     <= '0;
`endif
                end
            end else if (xfer) begin
                word_cnt <= word_cnt + CW'(1);
`ifdef ARB_WATCHDOG_EN
                wdog     <= '0;
`endif
                if (word_cnt == CW'(FRAME_LEN - 1)) begin
                    state      <= IDLE;
                    grant      <= '0;
                    rr_ptr     <= owner_nxt;
                    frame_done <= 1'b1;
                end
            end
`ifdef ARB_WATCHDOG_EN
            // only owner-idle cycles count; fifo_full stalls leave the counter alone
            else if (!req_valid[owner] && !fifo_full) begin
                if (wdog == WW'(WDOG_CYCLES - 1)) begin
                    state  <= IDLE;
                    grant  <= '0;
                    rr_ptr <= owner_nxt;
                    abort  <= 1'b1;
                    wdog   <= '0;
                end else begin
                    wdog <= wdog + WW'(1);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_fec_fifo_wr_arbiter.sv
// tb_fec_fifo_wr_arbiter: scoreboard bench for the frame-granting FIFO write arbiter.
module tb_fec_fifo_wr_arbiter;
    localparam int N = 2, W = 8, FL = 8, WD = 16;

    logic           clk = 1'b0, rst = 1'b1, fifo_full = 1'b0;
    logic [N-1:0]   req_valid = '0, req_ready, grant;
    logic [N*W-1:0] req_data = '0;
    logic           fifo_wr_en, busy, frame_done, abort;
    logic [W-1:0]   fifo_data;

    typedef struct {logic [W-1:0] data; logic [N-1:0] owner;} exp_t;
    exp_t sb[$];
    int nxt[N], exp_next[N], quota[N];
    int errors = 0, checks = 0;
    logic         obs_wr, obs_busy, obs_done, obs_abort;
    logic [N-1:0] obs_grant, obs_ready;

    fec_fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .FRAME_LEN(FL), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .grant(grant),
        .busy(busy), .frame_done(frame_done), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = quota[i] > 0;
            req_data[i*W +: W] = W'(nxt[i]);
        end
    endtask

    task automatic push_frame(input int i, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.data  = W'(exp_next[i]);
            e.owner = N'(1) << i;
            sb.push_back(e);
            exp_next[i]++;
        end
    endtask

    // sample one cycle at the falling edge, score any write, then advance the sources
    task automatic tick();
        logic [N-1:0] acc;
        exp_t e;
        @(negedge clk);
        obs_wr = fifo_wr_en; obs_busy = busy; obs_done = frame_done;
        obs_abort = abort; obs_grant = grant; obs_ready = req_ready;
        acc = req_valid & req_ready;
        if (!rst) begin
            checks++;
            if (fifo_wr_en && fifo_full) begin
                errors++; $display("FAIL wr_while_full: fifo_wr_en=%b fifo_full=%b, required no write", fifo_wr_en, fifo_full);
            end
            checks++;
            if (!fifo_wr_en && fifo_data !== '0) begin
                errors++; $display("FAIL idle_data: fifo_data=%h, required 00", fifo_data);
            end
            if (fifo_wr_en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL unexpected_write: data=%h grant=%b, required no write", fifo_data, grant);
                end else begin
                    e = sb.pop_front();
                    if (fifo_data !== e.data || grant !== e.owner) begin
                        errors++;
                        $display("FAIL scoreboard: data=%h grant=%b, required data=%h grant=%b", fifo_data, grant, e.data, e.owner);
                    end
                end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) if (acc[i]) begin nxt[i]++; quota[i]--; end
        apply();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({grant, req_ready, fifo_wr_en, fifo_data, busy, frame_done, abort} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b ready=%b wr=%b data=%h busy=%b done=%b abort=%b, required all 0",
                     grant, req_ready, fifo_wr_en, fifo_data, busy, frame_done, abort);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        quota[0] = FL; apply(); push_frame(0, FL);
        tick(); checks++;
        if (obs_busy !== 1'b0 || obs_wr !== 1'b0 || obs_grant !== '0) begin
            errors++; $display("FAIL sf_latency: busy=%b wr=%b grant=%b, required 0 0 00", obs_busy, obs_wr, obs_grant);
        end
        for (int k = 0; k < FL; k++) begin
            tick(); checks++;
            if (obs_wr !== 1'b1 || obs_grant !== 2'b01 || obs_done !== 1'b0) begin
                errors++; $display("FAIL sf_word%0d: wr=%b grant=%b done=%b, required 1 01 0", k, obs_wr, obs_grant, obs_done);
            end
        end
        tick(); checks++;
        if (obs_done !== 1'b1 || obs_grant !== '0 || obs_busy !== 1'b0) begin
            errors++; $display("FAIL sf_done: done=%b grant=%b busy=%b, required 1 00 0", obs_done, obs_grant, obs_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] own;
        quota[0] = 2*FL; quota[1] = 2*FL; apply();
        push_frame(1, FL); push_frame(0, FL); push_frame(1, FL); push_frame(0, FL);
        for (int f = 0; f < 4; f++) begin
            tick(); checks++;
            if (obs_wr !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'(f > 0)) begin
                errors++; $display("FAIL b2b_gap%0d: wr=%b busy=%b done=%b, required 0 0 %0d", f, obs_wr, obs_busy, obs_done, f > 0);
            end
            own = (f % 2 == 0) ? 2'b10 : 2'b01;
            for (int k = 0; k < FL; k++) begin
                tick(); checks++;
                if (obs_wr !== 1'b1 || obs_grant !== own) begin
                    errors++; $display("FAIL b2b_f%0d_w%0d: wr=%b grant=%b, required 1 %b", f, k, obs_wr, obs_grant, own);
                end
            end
        end
        tick(); checks++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_end: done=%b busy=%b, required 1 0", obs_done, obs_busy);
        end
    endtask

    task automatic test_full_stall();
        quota[0] = FL; apply(); push_frame(0, FL);
        tick();
        for (int k = 0; k < 3; k++) tick();
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(); checks++;
            if (obs_wr !== 1'b0 || obs_ready !== '0 || obs_busy !== 1'b1 || obs_abort !== 1'b0) begin
                errors++; $display("FAIL stall%0d: wr=%b ready=%b busy=%b abort=%b, required 0 00 1 0", k, obs_wr, obs_ready, obs_busy, obs_abort);
            end
        end
        fifo_full = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); checks++;
            if (obs_wr !== 1'b1 || obs_ready !== 2'b01) begin
                errors++; $display("FAIL stall_resume%0d: wr=%b ready=%b, required 1 01", k, obs_wr, obs_ready);
            end
        end
        tick(); checks++;
        if (obs_done !== 1'b1 || obs_abort !== 1'b0) begin
            errors++; $display("FAIL stall_done: done=%b abort=%b, required 1 0", obs_done, obs_abort);
        end
    endtask

    task automatic test_full_last();
        quota[1] = FL; apply(); push_frame(1, FL);
        tick();
        for (int k = 0; k < FL - 1; k++) tick();
        fifo_full = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick(); checks++;
            if (obs_wr !== 1'b0 || obs_done !== 1'b0 || obs_busy !== 1'b1 || obs_grant !== 2'b10) begin
                errors++; $display("FAIL last_block%0d: wr=%b done=%b busy=%b grant=%b, required 0 0 1 10", k, obs_wr, obs_done, obs_busy, obs_grant);
            end
        end
        fifo_full = 1'b0;
        tick(); checks++;
        if (obs_wr !== 1'b1) begin
            errors++; $display("FAIL last_write: wr=%b, required 1", obs_wr);
        end
        tick(); checks++;
        if (obs_done !== 1'b1 || obs_busy !== 1'b0) begin
            errors++; $display("FAIL last_done: done=%b busy=%b, required 1 0", obs_done, obs_busy);
        end
    endtask

    task automatic test_idle_owner();
        quota[1] = 3; apply(); push_frame(1, 3);
        tick();
        for (int k = 0; k < 3; k++) tick();
`ifdef ARB_WATCHDOG_EN
        for (int k = 0; k < WD; k++) begin
            tick(); checks++;
            if (obs_busy !== 1'b1 || obs_abort !== 1'b0 || obs_wr !== 1'b0) begin
                errors++; $display("FAIL wd_wait%0d: busy=%b abort=%b wr=%b, required 1 0 0", k, obs_busy, obs_abort, obs_wr);
            end
        end
        quota[0] = FL; apply(); push_frame(0, FL);
        tick(); checks++;
        if (obs_abort !== 1'b1 || obs_busy !== 1'b0 || obs_grant !== '0 || obs_done !== 1'b0) begin
            errors++; $display("FAIL wd_abort: abort=%b busy=%b grant=%b done=%b, required 1 0 00 0", obs_abort, obs_busy, obs_grant, obs_done);
        end
        for (int k = 0; k < FL; k++) begin
            tick(); checks++;
            if (obs_wr !== 1'b1 || obs_grant !== 2'b01 || obs_abort !== 1'b0) begin
                errors++; $display("FAIL wd_next%0d: wr=%b grant=%b abort=%b, required 1 01 0", k, obs_wr, obs_grant, obs_abort);
            end
        end
        tick(); checks++;
        if (obs_done !== 1'b1) begin
            errors++; $display("FAIL wd_next_done: done=%b, required 1", obs_done);
        end
`else
        for (int k = 0; k < 30; k++) begin
            tick(); checks++;
            if (obs_busy !== 1'b1 || obs_grant !== 2'b10 || obs_abort !== 1'b0 || obs_wr !== 1'b0) begin
                errors++; $display("FAIL hold%0d: busy=%b grant=%b abort=%b wr=%b, required 1 10 0 0", k, obs_busy, obs_grant, obs_abort, obs_wr);
            end
        end
        quota[1] = FL - 3; apply(); push_frame(1, FL - 3);
        for (int k = 0; k < FL - 3; k++) begin
            tick(); checks++;
            if (obs_wr !== 1'b1 || obs_grant !== 2'b10) begin
                errors++; $display("FAIL hold_resume%0d: wr=%b grant=%b, required 1 10", k, obs_wr, obs_grant);
            end
        end
        tick(); checks++;
        if (obs_done !== 1'b1 || obs_abort !== 1'b0) begin
            errors++; $display("FAIL hold_done: done=%b abort=%b, required 1 0", obs_done, obs_abort);
        end
`endif
    endtask

    task automatic test_reset_mid_frame();
        quota[1] = FL; apply(); push_frame(1, 5);
        tick();
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1; quota[1] = 0; apply();
        #1; checks++;
        if ({grant, req_ready, fifo_wr_en, fifo_data, busy, frame_done, abort} !== '0) begin
            errors++;
            $display("FAIL async_reset: grant=%b ready=%b wr=%b data=%h busy=%b done=%b abort=%b, required all 0",
                     grant, req_ready, fifo_wr_en, fifo_data, busy, frame_done, abort);
        end
        tick(); tick();
        rst = 1'b0;
        quota[0] = FL; quota[1] = FL; apply();
        push_frame(0, FL); push_frame(1, FL);
        tick(); checks++;
        if (obs_grant !== '0 || obs_busy !== 1'b0) begin
            errors++; $display("FAIL rst_idle: grant=%b busy=%b, required 00 0", obs_grant, obs_busy);
        end
        for (int k = 0; k < FL; k++) begin
            tick(); checks++;
            if (obs_wr !== 1'b1 || obs_grant !== 2'b01) begin
                errors++; $display("FAIL rst_frame%0d: wr=%b grant=%b, required 1 01", k, obs_wr, obs_grant);
            end
        end
        tick(); checks++;
        if (obs_done !== 1'b1) begin
            errors++; $display("FAIL rst_done: done=%b, required 1", obs_done);
        end
        for (int k = 0; k < FL + 1; k++) tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            nxt[i] = i * 64 + 1; exp_next[i] = i * 64 + 1; quota[i] = 0;
        end
        apply();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_full_stall();
        test_full_last();
        test_idle_owner();
        test_reset_mid_frame();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: %0d words never written, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
